// File: rtl/spi_slave_if.sv
// SPI slave interface: synchronizes the asynchronous SPI pins into clk_in and shifts
// LEN-bit frames in both directions, with a one-entry transmit buffer.
module spi_slave_if #(
  parameter int LEN = 8
) (
  input  logic           clk_in,
  input  logic           rst_n,
  input  logic           sclk_i,
  input  logic           ss_n_i,
  input  logic           mosi_i,
  output logic           miso_o,
  output logic           miso_oe,
  input  logic           cpol,
  input  logic           cpha,
  input  logic           lsb,
  input  logic [LEN-1:0] tx_data,
  input  logic           tx_valid,
  output logic           tx_ready,
  output logic [LEN-1:0] rx_data,
  output logic           rx_valid,
  output logic           busy,
  output logic           udr
);

  localparam int CW = (LEN > 2) ? $clog2(LEN) : 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t         state_q;
  logic [1:0]     sclkSync_q, ssSync_q, mosiSync_q, live_q;
  logic           sclkPrev_q, ssPrev_q, armed_q;
  logic [CW-1:0]  cnt_q;
  logic [LEN-1:0] txShift_q, rxShift_q, rxData_q, buf_q;
  logic           bufValid_q, miso_q, done_q, rxValid_q, udr_q;

  logic           isActive, sclkEdge, leadEdge, trailEdge, sampleEdge, driveEdge;
  logic           ssFall, ssRise, wordDone, loadShift, handshake;
  logic [LEN-1:0] loadWord_d, rxNext_d;

  always_comb begin
    isActive   = (state_q == ACTIVE);
    sclkEdge   = sclkSync_q[1] ^ sclkPrev_q;
    leadEdge   = sclkEdge & (sclkSync_q[1] != cpol);
    trailEdge  = sclkEdge & (sclkSync_q[1] == cpol);
    sampleEdge = isActive & (cpha ? trailEdge : leadEdge);
    driveEdge  = isActive & (cpha ? leadEdge : trailEdge);
    // The ss reset value of 1 is not a real observation, so a falling edge only
    // counts once ss_n has genuinely been seen high after reset.
    ssFall     = armed_q & ~ssSync_q[1] & ssPrev_q;
    ssRise     = ssSync_q[1] & ~ssPrev_q;
    wordDone   = sampleEdge & ~ssRise & (cnt_q == CW'(LEN - 1));
    loadShift  = ((state_q == IDLE) & ssFall) | wordDone;
    handshake  = tx_valid & ~bufValid_q;
    loadWord_d = bufValid_q ? buf_q : '0;
    rxNext_d   = lsb ? {mosiSync_q[1], rxShift_q[LEN-1:1]}
                     : {rxShift_q[LEN-2:0], mosiSync_q[1]};
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sclkSync_q <= 2'b00;
      ssSync_q   <= 2'b11;
      mosiSync_q <= 2'b00;
      live_q     <= 2'b00;
      sclkPrev_q <= 1'b0;
      ssPrev_q   <= 1'b1;
      armed_q    <= 1'b0;
      cnt_q      <= '0;
      txShift_q  <= '0;
      rxShift_q  <= '0;
      rxData_q   <= '0;
      buf_q      <= '0;
      bufValid_q <= 1'b0;
      miso_q     <= 1'b0;
      done_q     <= 1'b0;
      rxValid_q  <= 1'b0;
      udr_q      <= 1'b0;
    end else begin
      sclkSync_q <= {sclkSync_q[0], sclk_i};
      ssSync_q   <= {ssSync_q[0], ss_n_i};
      mosiSync_q <= {mosiSync_q[0], mosi_i};
      live_q     <= {live_q[0], 1'b1};
      sclkPrev_q <= sclkSync_q[1];
      ssPrev_q   <= ssSync_q[1];
      if (live_q[1] && ssSync_q[1]) armed_q <= 1'b1;

      done_q    <= wordDone;
      rxValid_q <= done_q;
      udr_q     <= loadShift & ~bufValid_q;

      // A handshake in the same cycle as a load refills the buffer after it drains.
      if (loadShift) bufValid_q <= 1'b0;
      if (handshake) begin
        buf_q      <= tx_data;
        bufValid_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (ssFall) begin
            state_q <= ACTIVE;
            cnt_q   <= '0;
          end
        end
        ACTIVE: begin
          if (ssRise) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            txShift_q <= '0;
            rxShift_q <= '0;
            miso_q    <= 1'b0;
          end else if (sampleEdge) begin
            rxShift_q <= rxNext_d;
            if (cnt_q == CW'(LEN - 1)) begin
              cnt_q    <= '0;
              rxData_q <= rxNext_d;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end else if (driveEdge && cnt_q != '0) begin
            if (lsb) begin
              txShift_q <= txShift_q >> 1;
              miso_q    <= txShift_q[1];
            end else begin
              txShift_q <= txShift_q << 1;
              miso_q    <= txShift_q[LEN-2];
            end
          end
        end
        default: state_q <= IDLE;
      endcase

      if (loadShift) begin
        txShift_q <= loadWord_d;
        miso_q    <= lsb ? loadWord_d[0] : loadWord_d[LEN-1];
      end
    end
  end

  assign busy     = (state_q == ACTIVE);
  assign miso_oe  = busy;
  assign miso_o   = miso_q & busy;
  assign tx_ready = ~bufValid_q;
  assign rx_data  = rxData_q;
  assign rx_valid = rxValid_q;
  assign udr      = udr_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: a behavioural SPI master plus a queue-based model of the
// tx buffer and expected received words, directed cases followed by random frames.
module tb_spi_slave_if;

  localparam int LEN  = 8;
  localparam int HALF = 6;

  logic           clk_in = 1'b0;
  logic           rst_n;
  logic           sclk_i, ss_n_i, mosi_i;
  logic           miso_o, miso_oe;
  logic           cpol, cpha, lsb;
  logic [LEN-1:0] tx_data;
  logic           tx_valid, tx_ready;
  logic [LEN-1:0] rx_data;
  logic           rx_valid, busy, udr;

  int total = 0;
  int bad   = 0;

  logic [LEN-1:0] txQ[$];
  logic [LEN-1:0] expRx[$];
  logic [LEN-1:0] rxQ[$];
  logic [LEN-1:0] curTx;
  logic [LEN-1:0] lastRxExp;
  int             udrExp    = 0;
  int             udrPulses = 0;

  spi_slave_if #(.LEN(LEN)) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .sclk_i   (sclk_i),
    .ss_n_i   (ss_n_i),
    .mosi_i   (mosi_i),
    .miso_o   (miso_o),
    .miso_oe  (miso_oe),
    .cpol     (cpol),
    .cpha     (cpha),
    .lsb      (lsb),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .udr      (udr)
  );

  always #5 clk_in = ~clk_in;

  // Each cycle of rx_valid high logs one word, so a stretched pulse shows up as an extra word.
  always @(posedge clk_in) begin
    #1;
    if (rx_valid) rxQ.push_back(rx_data);
    if (udr) udrPulses++;
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic takeTx();
    if (txQ.size() > 0) curTx = txQ.pop_front();
    else begin
      curTx = '0;
      udrExp++;
    end
  endtask

  task automatic pushTx(input logic [LEN-1:0] w);
    int n = 0;
    while (!tx_ready && n < 50) begin
      waitCycles(1);
      n++;
    end
    checkOutput("txReady", 32'(tx_ready), 32'd1);
    tx_data  = w;
    tx_valid = 1'b1;
    waitCycles(1);
    tx_valid = 1'b0;
    txQ.push_back(w);
    checkOutput("txReadyLow", 32'(tx_ready), 32'd0);
  endtask

  task automatic setMode(input logic cp, input logic ch, input logic l);
    cpol   = cp;
    cpha   = ch;
    lsb    = l;
    sclk_i = cp;
    waitCycles(8);
  endtask

  task automatic ssLow();
    ss_n_i = 1'b0;
    takeTx();
    waitCycles(10);
    checkOutput("busyActive", 32'(busy), 32'd1);
    checkOutput("misoOeActive", 32'(miso_oe), 32'd1);
    checkOutput("udrAtStart", 32'(udrPulses), 32'(udrExp));
    checkOutput("misoFirstBit", 32'(miso_o), 32'(lsb ? curTx[0] : curTx[LEN-1]));
  endtask

  task automatic ssHigh();
    ss_n_i = 1'b1;
    mosi_i = 1'b0;
    waitCycles(10);
    checkOutput("busyIdle", 32'(busy), 32'd0);
    checkOutput("misoIdle", 32'(miso_o), 32'd0);
    checkOutput("misoOeIdle", 32'(miso_oe), 32'd0);
  endtask

  task automatic shiftBits(input logic [LEN-1:0] mosiWord, input int nbits,
                           output logic [LEN-1:0] readWord);
    readWord = '0;
    for (int i = 0; i < nbits; i++) begin
      int idx;
      idx = lsb ? i : LEN - 1 - i;
      if (!cpha) begin
        mosi_i = mosiWord[idx];
        waitCycles(HALF);
        sclk_i        = ~cpol;
        readWord[idx] = miso_o;
        waitCycles(HALF);
        sclk_i = cpol;
      end else begin
        sclk_i = ~cpol;
        mosi_i = mosiWord[idx];
        waitCycles(HALF);
        sclk_i        = cpol;
        readWord[idx] = miso_o;
        waitCycles(HALF);
      end
    end
    waitCycles(HALF);
  endtask

  task automatic runWord(input logic [LEN-1:0] mosiWord);
    logic [LEN-1:0] got;
    shiftBits(mosiWord, LEN, got);
    checkOutput("masterRead", 32'(got), 32'(curTx));
    expRx.push_back(mosiWord);
    lastRxExp = mosiWord;
    takeTx();
  endtask

  task automatic verifyFrame();
    checkOutput("rxCount", 32'(rxQ.size()), 32'(expRx.size()));
    while (rxQ.size() > 0 && expRx.size() > 0)
      checkOutput("rxWord", 32'(rxQ.pop_front()), 32'(expRx.pop_front()));
    rxQ.delete();
    expRx.delete();
    checkOutput("udrCount", 32'(udrPulses), 32'(udrExp));
    checkOutput("rxDataHeld", 32'(rx_data), 32'(lastRxExp));
    udrPulses = 0;
    udrExp    = 0;
  endtask

  task automatic applyStimulus();
    logic [LEN-1:0] partial;
    logic [1:0]     m;
    int             nw;

    rst_n = 1'b0; sclk_i = 1'b0; ss_n_i = 1'b1; mosi_i = 1'b0;
    cpol = 1'b0; cpha = 1'b0; lsb = 1'b0; tx_data = '0; tx_valid = 1'b0;
    lastRxExp = '0;
    waitCycles(3);
    checkOutput("rstMiso", 32'(miso_o), 32'd0);
    checkOutput("rstMisoOe", 32'(miso_oe), 32'd0);
    checkOutput("rstTxReady", 32'(tx_ready), 32'd1);
    checkOutput("rstRxData", 32'(rx_data), 32'd0);
    checkOutput("rstRxValid", 32'(rx_valid), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstUdr", 32'(udr), 32'd0);
    rst_n = 1'b1;
    waitCycles(5);

    $display("[TB] mode 0 msb-first single word");
    setMode(1'b0, 1'b0, 1'b0);
    pushTx(8'hA5); ssLow(); runWord(8'h3C); ssHigh(); verifyFrame();

    $display("[TB] mode 3 lsb-first single word");
    setMode(1'b1, 1'b1, 1'b1);
    pushTx(8'h81); ssLow(); runWord(8'h7E); ssHigh(); verifyFrame();

    $display("[TB] mode 1 underrun");
    setMode(1'b0, 1'b1, 1'b0);
    ssLow(); runWord(8'hFF); ssHigh(); verifyFrame();

    $display("[TB] back-to-back words");
    setMode(1'b0, 1'b0, 1'b0);
    pushTx(8'h55); ssLow(); pushTx(8'hAA);
    runWord(8'h12); runWord(8'h34); ssHigh(); verifyFrame();

    $display("[TB] abort after 5 bits");
    pushTx(8'h99); ssLow();
    shiftBits(8'hF0, 5, partial);
    ssHigh(); verifyFrame();
    pushTx(8'hC3); ssLow(); runWord(8'h5A); ssHigh(); verifyFrame();

    $display("[TB] reset mid-frame");
    pushTx(8'h6E); ssLow();
    shiftBits(8'h0F, 3, partial);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstMiso", 32'(miso_o), 32'd0);
    checkOutput("midRstMisoOe", 32'(miso_oe), 32'd0);
    checkOutput("midRstTxReady", 32'(tx_ready), 32'd1);
    checkOutput("midRstRxData", 32'(rx_data), 32'd0);
    checkOutput("midRstRxValid", 32'(rx_valid), 32'd0);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstUdr", 32'(udr), 32'd0);
    ss_n_i = 1'b1; sclk_i = cpol; mosi_i = 1'b0;
    txQ.delete(); expRx.delete(); rxQ.delete();
    udrPulses = 0; udrExp = 0; lastRxExp = '0;
    waitCycles(4);
    rst_n = 1'b1;
    waitCycles(6);
    pushTx(8'hB7); ssLow(); runWord(8'hE1); ssHigh(); verifyFrame();

    $display("[TB] random frames");
    for (int it = 0; it < 8; it++) begin
      m  = 2'($urandom_range(0, 3));
      nw = $urandom_range(1, 2);
      setMode(m[1], m[0], 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) pushTx(LEN'($urandom));
      ssLow();
      for (int w = 0; w < nw; w++) begin
        if (w < nw - 1 && $urandom_range(0, 1) == 1) pushTx(LEN'($urandom));
        runWord(LEN'($urandom));
      end
      ssHigh();
      verifyFrame();
    end
  endtask

  initial begin
    applyStimulus();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
